// File: rtl/float_to_int.sv
// Multi-cycle IEEE-754 to signed integer converter (truncation toward zero).
// A fraction accumulator is shifted one bit per cycle until it is aligned with the integer LSB.
module float_to_int #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INT_WIDTH-1:0]  out_data,
  output logic [2:0]            out_flags
);

  localparam int unsigned EXP_W = (DATA_WIDTH == 16) ? 5  : (DATA_WIDTH == 64) ? 11 : 8;
  localparam int unsigned MAN_W = (DATA_WIDTH == 16) ? 10 : (DATA_WIDTH == 64) ? 52 : 23;
  localparam int unsigned FLT_W = 1 + EXP_W + MAN_W;
  localparam int unsigned ACC_W = ((MAN_W + 1) > INT_WIDTH) ? (MAN_W + 1) : INT_WIDTH;
  localparam int unsigned CNT_W = $clog2(ACC_W + 1);
  localparam int          BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int          MAN_I = int'(MAN_W);
  localparam int          SAT_E = int'(INT_WIDTH) - 1;
  localparam logic [INT_WIDTH-1:0] INT_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic [INT_WIDTH-1:0] INT_MIN = {1'b1, {(INT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                 accept;
  logic [FLT_W-1:0]     flt;
  logic                 sgn_c;
  logic [EXP_W-1:0]     exp_c;
  logic [MAN_W-1:0]     man_c;
  int                   e_c;

  logic                 dec_spec;
  logic                 dec_left;
  logic [CNT_W-1:0]     dec_cnt;
  logic [INT_WIDTH-1:0] dec_data;
  logic [2:0]           dec_flags;

  logic [ACC_W-1:0]     acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 left_q;
  logic                 neg_q;
  logic                 spec_q;
  logic [INT_WIDTH-1:0] spec_data_q;
  logic [2:0]           flags_q;
  logic [INT_WIDTH-1:0] mag;

  assign accept = in_valid && in_ready;

  // Unsupported widths are viewed through the single-precision layout
  assign flt   = FLT_W'(in_data);
  assign sgn_c = flt[FLT_W-1];
  assign exp_c = flt[FLT_W-2 -: EXP_W];
  assign man_c = flt[MAN_W-1:0];
  assign e_c   = int'(exp_c) - BIAS;

  // Classify the incoming value; special results bypass the shifter entirely
  always_comb begin
    dec_spec  = 1'b0;
    dec_left  = 1'b0;
    dec_cnt   = '0;
    dec_data  = '0;
    dec_flags = '0;
    if (exp_c == '0) begin
      dec_spec     = 1'b1;
      dec_flags[0] = |man_c;
    end else if (exp_c == '1) begin
      dec_spec     = 1'b1;
      dec_flags[2] = 1'b1;
      dec_data     = ((man_c != '0) || !sgn_c) ? INT_MAX : INT_MIN;
    end else if (e_c < 0) begin
      dec_spec     = 1'b1;
      dec_flags[0] = 1'b1;
    end else if (e_c >= SAT_E) begin
      dec_spec = 1'b1;
      if (sgn_c && (e_c == SAT_E) && (man_c == '0)) begin
        dec_data = INT_MIN;
      end else begin
        dec_data     = sgn_c ? INT_MIN : INT_MAX;
        dec_flags[1] = 1'b1;
      end
    end else if (e_c > MAN_I) begin
      dec_left = 1'b1;
      dec_cnt  = CNT_W'(e_c - MAN_I);
    end else begin
      dec_cnt  = CNT_W'(MAN_I - e_c);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign mag = acc_q[INT_WIDTH-1:0];

  // Datapath: load at accept, shift one bit per cycle, finalize when the count is exhausted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      left_q      <= 1'b0;
      neg_q       <= 1'b0;
      spec_q      <= 1'b0;
      spec_data_q <= '0;
      flags_q     <= '0;
      out_data    <= '0;
      out_flags   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q       <= ACC_W'({1'b1, man_c});
            cnt_q       <= dec_cnt;
            left_q      <= dec_left;
            neg_q       <= sgn_c;
            spec_q      <= dec_spec;
            spec_data_q <= dec_data;
            flags_q     <= dec_flags;
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (left_q) begin
              acc_q <= acc_q << 1;
            end else begin
              acc_q      <= acc_q >> 1;
              flags_q[0] <= flags_q[0] | acc_q[0];
            end
          end else begin
            // Sign is applied only after the magnitude is fully aligned
            if (spec_q) begin
              out_data <= spec_data_q;
            end else if (neg_q) begin
              out_data <= (~mag) + INT_WIDTH'(1);
            end else begin
              out_data <= mag;
            end
            out_flags <= flags_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int.sv
// Directed bench for float_to_int (32-bit float -> 32-bit int) with an arithmetic reference model.
module tb_float_to_int;

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 32;
  localparam int          NV = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_data;
  logic [2:0]    out_flags;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_data  = '0;
  logic [2:0]  exp_flags = '0;

  float_to_int #(.DATA_WIDTH(DW), .INT_WIDTH(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: value = 1.mantissa * 2^e, computed with plain integer arithmetic
  function automatic void model(input logic [31:0] f, output logic [31:0] d,
                                output logic [2:0] fl, output int n);
    logic   s;
    int     e;
    longint frac;
    longint mag;
    longint scale;
    s    = f[31];
    e    = int'(f[30:23]) - 127;
    frac = longint'({1'b1, f[22:0]});
    d    = '0;
    fl   = '0;
    n    = 0;
    if (f[30:23] == 8'h00) begin
      fl[0] = (f[22:0] != 23'd0);
    end else if (f[30:23] == 8'hFF) begin
      fl[2] = 1'b1;
      d     = ((f[22:0] != 23'd0) || !s) ? 32'h7FFF_FFFF : 32'h8000_0000;
    end else if (e < 0) begin
      fl[0] = 1'b1;
    end else if (e >= 31) begin
      if (s && e == 31 && f[22:0] == 23'd0) begin
        d = 32'h8000_0000;
      end else begin
        fl[1] = 1'b1;
        d     = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
    end else begin
      if (e >= 23) begin
        scale = longint'(1) << (e - 23);
        mag   = frac * scale;
        n     = e - 23;
      end else begin
        scale = longint'(1) << (23 - e);
        mag   = frac / scale;
        fl[0] = (frac % scale) != 0;
        n     = 23 - e;
      end
      d = s ? 32'(-mag) : 32'(mag);
    end
  endfunction

  // Output checker: every cycle a result is presented it must match the model and hold steady
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      chk("out_data", 64'(out_data), 64'(exp_data));
      chk("out_flags", 64'(out_flags), 64'(exp_flags));
      chk("in_ready_in_done", 64'(in_ready), 64'd0);
    end
  end

  task automatic run(input logic [31:0] f, input int hold, input bit rel);
    logic [31:0] md;
    logic [2:0]  mf;
    int          mn;
    int          cyc;
    model(f, md, mf, mn);
    @(negedge clk);
    if (rel) rst_n = 1'b1;
    exp_data  = md;
    exp_flags = mf;
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_data   = f;
    #1;
    chk("in_ready_at_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom();
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(mn + 1));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      in_data = $urandom();
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("valid_drop", 64'(out_valid), 64'd0);
    chk("ready_back", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  logic [31:0] vf [NV] = '{
    32'h3F80_0000, 32'hC020_0000, 32'h4E80_0000, 32'h4F32_D05E,
    32'hCF00_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h3F00_0000,
    32'h0000_0001, 32'h8000_0000, 32'hC2C8_0000, 32'h4070_0000,
    32'h4B3C_614E, 32'h4EFF_FFFF, 32'h3FC0_0000, 32'h4F00_0000
  };
  logic [31:0] vd [NV] = '{
    32'h0000_0001, 32'hFFFF_FFFE, 32'h4000_0000, 32'h7FFF_FFFF,
    32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000, 32'hFFFF_FF9C, 32'h0000_0003,
    32'h00BC_614E, 32'h7FFF_FF80, 32'h0000_0001, 32'h7FFF_FFFF
  };
  logic [2:0] vl [NV] = '{
    3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b100, 3'b001,
    3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 3'b010
  };
  int vn [NV] = '{23, 22, 7, 0, 0, 0, 0, 0, 0, 0, 17, 22, 0, 7, 23, 0};

  initial begin
    logic [31:0] md;
    logic [2:0]  mf;
    int          mn;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);

    for (int i = 0; i < NV; i++) begin
      model(vf[i], md, mf, mn);
      chk("model_data", 64'(md), 64'(vd[i]));
      chk("model_flags", 64'(mf), 64'(vl[i]));
      chk("model_shifts", 64'(mn), 64'(vn[i]));
      run(vf[i], (i == 1) ? 10 : (i % 3), (i == 0));
    end

    // Abort a conversion mid-shift with a one-edge reset
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h3F80_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_out_data", 64'(out_data), 64'd0);
    chk("abort_out_flags", 64'(out_flags), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run(32'hC020_0000, 2, 1'b0);
    run(32'h4070_0000, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/float_to_int.md
FLOAT_TO_INT -- requirements
Module: float_to_int

Interface
REQ-001 Parameter DATA_WIDTH, default 32: float input width; legal values 16, 32, 64 (exponent/mantissa widths 5/10, 8/23, 11/52; any other value behaves as 32).
REQ-002 Parameter INT_WIDTH, default 32: signed two's-complement result width; SHALL be at least 8.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  in_data holds a float to convert.
REQ-006 in_ready  output  1  block can accept; SHALL equal (state == IDLE).
REQ-007 in_data  input  DATA_WIDTH  IEEE-754 value {sign, exponent, mantissa}.
REQ-008 out_valid  output  1  out_data/out_flags valid; SHALL equal (state == DONE).
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_data  output  INT_WIDTH  signed integer result.
REQ-011 out_flags  output  3  {invalid, overflow, inexact}.

Function
REQ-012 FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on an input handshake (in_valid && in_ready) at edge T; SHIFT->DONE on the edge after the shift counter reaches zero; DONE->IDLE on the edge where out_ready is high; no input is accepted in the cycle DONE exits.
REQ-013 Decode at accept: bias = 2^(EXPONENT_WIDTH-1)-1, e = exponent - bias, fraction = {1, mantissa}, M = MANTISSA_WIDTH.
REQ-014 Normal case (exponent nonzero and not all-ones, 0 <= e <= INT_WIDTH-2): N = |e - M| single-bit shifts of the accumulator (left if e > M, right if e < M) at edges T+1..T+N; the result is finalized at edge T+N+1, so out_valid is high starting the cycle after edge T+N+1.
REQ-015 Special cases use N = 0 (out_valid high after edge T+1): exponent == 0 (zero/subnormal) -> 0, inexact = (mantissa != 0); e < 0 -> 0, inexact = 1; exponent all-ones with mantissa != 0 (NaN) -> 2^(INT_WIDTH-1)-1, invalid = 1; infinity -> saturate by sign, invalid = 1; e >= INT_WIDTH-1 -> saturate by sign, overflow = 1, except exactly -2^(INT_WIDTH-1), which returns 0x80..0 with no flags.
REQ-016 Rounding SHALL be truncation toward zero; inexact = OR of all bits shifted out on right shifts (sticky); left shifts never set inexact.
REQ-017 Sign SHALL be applied last: negative inputs return the two's complement of the magnitude; -0.0 returns 0.
REQ-018 In DONE, out_data and out_flags SHALL hold stable while out_ready is low (backpressure of any length).
REQ-019 in_data is sampled only at the accept edge; changes during SHIFT/DONE SHALL have no effect.
REQ-020 Throughput: one conversion per N+3 cycles when out_ready is held high.

Reset
REQ-021 rst_n low at a rising edge SHALL force state IDLE, out_data = 0, out_flags = 0, out_valid = 0, shift counter = 0, from any state including mid-SHIFT; the in-flight conversion is dropped with no output.
REQ-022 The first handshake SHALL be possible on the first edge where rst_n is high.

Verification
REQ-023 DATA_WIDTH=32, in 0x3F800000 (1.0) accepted at T -> out_valid after edge T+24, out_data 0x00000001, flags 000.
REQ-024 in 0xC0200000 (-2.5) -> out_data 0xFFFFFFFE, flags 001, N = 22; in 0x4E800000 (2^30) -> 0x40000000, flags 000, N = 7 left shifts.
REQ-025 in 0x4F32D05E (~3e9) -> 0x7FFFFFFF, flags 010 after one cycle; in 0xCF000000 -> 0x80000000, flags 000; in 0x7FC00000 (NaN) -> 0x7FFFFFFF, flags 100; in 0xFF800000 (-inf) -> 0x80000000, flags 100.
REQ-026 in 0x3F000000 (0.5) -> 0, flags 001; in 0x00000001 (subnormal) -> 0, flags 001; in 0x80000000 (-0.0) -> 0, flags 000.
REQ-027 Hold out_ready low 10 cycles in DONE -> out_data/out_flags constant and in_ready low throughout; raise out_ready -> IDLE on the next edge, in_ready high the cycle after.
REQ-028 Pull rst_n low for one edge mid-SHIFT -> outputs zeroed and in_ready high next cycle; the next input converts correctly with no residue from the aborted input.
